// File: rtl/frame_writer_pkg.sv
// Shared SDRAM command encodings, burst defaults and the frame writer state type.
package frame_writer_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    localparam int READ_BURST_LENGTH  = 8;
    localparam int WRITE_BURST_LENGTH = 8;
    localparam int SDRAM_ADDR_W       = 22;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2
    } fw_state_e;

endpackage

// File: rtl/frame_writer_addr.sv
// Word address counter that wraps at the frame size; shared with the read path.
module frame_addr_counter
    import frame_writer_pkg::*;
#(
    parameter int FRAME_WORDS = 96000
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_n,
    input  logic                    i_Clr,
    input  logic                    i_Inc,
    output logic [SDRAM_ADDR_W-1:0] o_Addr,
    output logic                    o_Last
);

    localparam logic [SDRAM_ADDR_W-1:0] LAST_ADDR = SDRAM_ADDR_W'(FRAME_WORDS - 1);

    logic [SDRAM_ADDR_W-1:0] addr_q, addr_d;

    // Clear wins over increment so a frame restart overrides the advance.
    always_comb begin
        addr_d = addr_q;
        if (i_Clr) begin
            addr_d = '0;
        end else if (i_Inc) begin
            addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign o_Addr = addr_q;
    assign o_Last = (addr_q == LAST_ADDR);

endmodule

// File: rtl/frame_writer.sv
// Drains the render output FIFO into the SDRAM frame buffer in fixed-length write bursts.
module frame_writer
    import frame_writer_pkg::*;
#(
    parameter int WRITE_BURST_LENGTH = frame_writer_pkg::WRITE_BURST_LENGTH,
    parameter int FRAME_WORDS        = 96000,
    parameter int FIFO_USED_WIDTH    = 10
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_n,
    input  logic                       i_Bus_Grant,
    input  logic                       i_Frame_Start,
    input  logic [FIFO_USED_WIDTH-1:0] i_Pixel_Out_Used,
    input  logic [31:0]                i_Pixel_Out_Data,
    output logic                       o_FIFO_Rd,
    input  logic                       i_Data_Write_Done,
    output logic [1:0]                 o_Command,
    output logic [SDRAM_ADDR_W-1:0]    o_Data_Address,
    output logic [31:0]                o_Data_Write,
    output logic                       o_Busy,
    output logic                       o_Frame_Done
);

    localparam logic [FIFO_USED_WIDTH-1:0] BURST_USED = FIFO_USED_WIDTH'(WRITE_BURST_LENGTH);
    localparam logic [7:0]                 BURST_M1   = 8'(WRITE_BURST_LENGTH - 1);

    fw_state_e   state_q, state_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  count_q, count_d;
    logic        frame_done_q, frame_done_d;
    logic        restart_q, restart_d;
    logic        addr_clr, addr_inc, addr_last, fifo_rd;
    logic        restart_now;

    frame_addr_counter #(
        .FRAME_WORDS(FRAME_WORDS)
    ) u_addr (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Clr   (addr_clr),
        .i_Inc   (addr_inc),
        .o_Addr  (o_Data_Address),
        .o_Last  (addr_last)
    );

    assign restart_now = restart_q | i_Frame_Start;

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        data_d       = data_q;
        count_d      = count_q;
        restart_d    = restart_q;
        frame_done_d = 1'b0;
        addr_clr     = 1'b0;
        addr_inc     = 1'b0;
        fifo_rd      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_d = CMD_IDLE;
                // A pending restart is served before a burst may start.
                if (restart_now) begin
                    addr_clr  = 1'b1;
                    restart_d = 1'b0;
                end else if (i_Bus_Grant && (i_Pixel_Out_Used >= BURST_USED)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                fifo_rd = 1'b1;
                data_d  = i_Pixel_Out_Data;
                count_d = BURST_M1;
                cmd_d   = CMD_WRITE;
                state_d = ST_WRITE;
                if (i_Frame_Start) restart_d = 1'b1;
            end
            ST_WRITE: begin
                if (i_Frame_Start) restart_d = 1'b1;
                if (i_Data_Write_Done) begin
                    addr_inc     = 1'b1;
                    frame_done_d = addr_last;
                    if (count_q != 8'd0) begin
                        count_d = count_q - 8'd1;
                        fifo_rd = 1'b1;
                        data_d  = i_Pixel_Out_Data;
                    end else begin
                        cmd_d   = CMD_IDLE;
                        state_d = ST_IDLE;
                        if (restart_now) begin
                            addr_clr  = 1'b1;
                            restart_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                cmd_d   = CMD_IDLE;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q      <= ST_IDLE;
            cmd_q        <= CMD_IDLE;
            data_q       <= '0;
            count_q      <= '0;
            frame_done_q <= 1'b0;
            restart_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            data_q       <= data_d;
            count_q      <= count_d;
            frame_done_q <= frame_done_d;
            restart_q    <= restart_d;
        end
    end

    assign o_FIFO_Rd    = fifo_rd;
    assign o_Command    = cmd_q;
    assign o_Data_Write = data_q;
    assign o_Busy       = (state_q != ST_IDLE);
    assign o_Frame_Done = frame_done_q;

endmodule

// File: tb/tb_frame_writer.sv
// Directed-sequence bench for frame_writer with random data and handshake gaps.
module tb_frame_writer;
    import frame_writer_pkg::*;

    localparam int BL = 8;
    localparam int FW = 48;
    localparam int UW = 10;

    logic          i_Clk = 1'b0;
    logic          i_Rst_n = 1'b0;
    logic          i_Bus_Grant = 1'b0;
    logic          i_Frame_Start = 1'b0;
    logic          i_Data_Write_Done = 1'b0;
    logic [UW-1:0] used = '0;
    logic [31:0]   pix = '0;
    logic          o_FIFO_Rd, o_Busy, o_Frame_Done;
    logic [1:0]    o_Command;
    logic [21:0]   o_Data_Address;
    logic [31:0]   o_Data_Write;

    frame_writer #(
        .WRITE_BURST_LENGTH(BL),
        .FRAME_WORDS(FW),
        .FIFO_USED_WIDTH(UW)
    ) dut (
        .i_Clk             (i_Clk),
        .i_Rst_n           (i_Rst_n),
        .i_Bus_Grant       (i_Bus_Grant),
        .i_Frame_Start     (i_Frame_Start),
        .i_Pixel_Out_Used  (used),
        .i_Pixel_Out_Data  (pix),
        .o_FIFO_Rd         (o_FIFO_Rd),
        .i_Data_Write_Done (i_Data_Write_Done),
        .o_Command         (o_Command),
        .o_Data_Address    (o_Data_Address),
        .o_Data_Write      (o_Data_Write),
        .o_Busy            (o_Busy),
        .o_Frame_Done      (o_Frame_Done)
    );

    always #5 i_Clk = ~i_Clk;

    // Render FIFO model (show-ahead) and the scoreboard of words still owed to SDRAM.
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          fd_count = 0;
    int          exp_addr = 0;
    bit          rd_s = 1'b0;
    logic [31:0] pop_dummy;

    always @(negedge i_Clk) begin
        rd_s = o_FIFO_Rd;
        pix  = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
        used = UW'(fifo_q.size());
        fd_count += int'(o_Frame_Done);
    end

    always @(posedge i_Clk) begin
        if (rd_s && fifo_q.size() > 0) pop_dummy = fifo_q.pop_front();
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic push(input int n);
        logic [31:0] w;
        repeat (n) begin
            w = $urandom;
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic expect_start();
        cyc();
        chk("load_cmd", 32'(o_Command), 32'(CMD_IDLE));
        chk("load_busy", 32'(o_Busy), 32'd1);
        chk("load_pop", 32'(o_FIFO_Rd), 32'd1);
        cyc();
        chk("start_cmd", 32'(o_Command), 32'(CMD_WRITE));
    endtask

    task automatic run_burst(input int gmin, input int gmax, input int hold_idx,
                             input int hold_len, input int fs_idx);
        int waited;
        int n0;
        int gap;
        bit restart;
        logic [31:0] d;
        waited  = 0;
        restart = 1'b0;
        while (o_Command !== CMD_WRITE && waited < 40) begin
            cyc();
            waited++;
        end
        chk("burst_start_timeout", 32'(waited < 40), 32'd1);
        if (waited >= 40) return;
        n0 = fifo_q.size();
        for (int w = 0; w < BL; w++) begin
            gap = (w == hold_idx) ? hold_len : $urandom_range(gmax, gmin);
            i_Data_Write_Done = 1'b0;
            repeat (gap) begin
                cyc();
                chk("stall_cmd", 32'(o_Command), 32'(CMD_WRITE));
                chk("stall_addr", 32'(o_Data_Address), 32'(exp_addr));
                chk("stall_data", o_Data_Write, exp_q[0]);
                chk("stall_pop", 32'(o_FIFO_Rd), 32'd0);
            end
            i_Data_Write_Done = 1'b1;
            if (w == fs_idx) i_Frame_Start = 1'b1;
            #1;
            chk("acc_cmd", 32'(o_Command), 32'(CMD_WRITE));
            chk("acc_addr", 32'(o_Data_Address), 32'(exp_addr));
            chk("acc_data", o_Data_Write, exp_q[0]);
            chk("acc_pop", 32'(o_FIFO_Rd), 32'(w != BL - 1));
            cyc();
            i_Data_Write_Done = 1'b0;
            i_Frame_Start = 1'b0;
            d = exp_q.pop_front();
            chk("frame_done", 32'(o_Frame_Done), 32'(exp_addr == FW - 1));
            exp_addr = (exp_addr + 1) % FW;
            if (w == fs_idx) restart = 1'b1;
        end
        if (restart) exp_addr = 0;
        chk("end_cmd", 32'(o_Command), 32'(CMD_IDLE));
        chk("end_busy", 32'(o_Busy), 32'd0);
        chk("end_addr", 32'(o_Data_Address), 32'(exp_addr));
        chk("burst_pops", 32'(fifo_q.size()), 32'(n0 - (BL - 1)));
    endtask

    initial begin
        int fd0;
        // Reset values
        repeat (2) @(posedge i_Clk);
        #1;
        chk("rst_cmd", 32'(o_Command), 32'(CMD_IDLE));
        chk("rst_addr", 32'(o_Data_Address), 32'd0);
        chk("rst_data", o_Data_Write, 32'd0);
        chk("rst_busy", 32'(o_Busy), 32'd0);
        chk("rst_pop", 32'(o_FIFO_Rd), 32'd0);
        chk("rst_fdone", 32'(o_Frame_Done), 32'd0);

        // Test 1: one burst, done every third cycle
        i_Bus_Grant = 1'b1;
        push(BL);
        i_Rst_n = 1'b1;
        expect_start();
        run_burst(2, 2, -1, 0, -1);

        // Test 2: one word short of a burst, then the eighth word arrives
        push(BL - 1);
        repeat (10) begin
            cyc();
            chk("short_cmd", 32'(o_Command), 32'(CMD_IDLE));
            chk("short_pop", 32'(o_FIFO_Rd), 32'd0);
        end
        push(1);
        expect_start();
        run_burst(0, 3, -1, 0, -1);

        // Grant low holds the burst back
        i_Bus_Grant = 1'b0;
        push(BL);
        repeat (6) begin
            cyc();
            chk("nogrant_busy", 32'(o_Busy), 32'd0);
        end
        i_Bus_Grant = 1'b1;
        expect_start();
        run_burst(0, 3, -1, 0, -1);

        // Frame start while idle clears the address
        i_Frame_Start = 1'b1;
        cyc();
        i_Frame_Start = 1'b0;
        exp_addr = 0;
        chk("idle_restart_addr", 32'(o_Data_Address), 32'(exp_addr));

        // Test 3: burst crossing the end of the frame
        while (exp_addr != FW - BL) begin
            push(BL);
            run_burst(0, 2, -1, 0, -1);
        end
        fd0 = fd_count;
        push(BL);
        run_burst(0, 1, -1, 0, -1);
        cyc();
        chk("frame_done_pulses", 32'(fd_count - fd0), 32'd1);
        chk("frame_done_low", 32'(o_Frame_Done), 32'd0);

        // Test 4: frame start during the third word of the burst at FW-BL
        while (exp_addr != FW - BL) begin
            push(BL);
            run_burst(0, 2, -1, 0, -1);
        end
        push(BL);
        run_burst(0, 2, -1, 0, 2);
        push(BL);
        run_burst(0, 2, -1, 0, -1);

        // Test 5: long stall mid-burst
        push(BL);
        run_burst(0, 1, 3, 20, -1);

        // Test 6: reset dropped mid-burst
        push(BL);
        expect_start();
        i_Data_Write_Done = 1'b1;
        repeat (3) cyc();
        i_Data_Write_Done = 1'b0;
        chk("pre_rst_addr", 32'(o_Data_Address), 32'(exp_addr + 3));
        i_Rst_n = 1'b0;
        #1;
        chk("async_rst_cmd", 32'(o_Command), 32'(CMD_IDLE));
        chk("async_rst_addr", 32'(o_Data_Address), 32'd0);
        chk("async_rst_busy", 32'(o_Busy), 32'd0);
        chk("async_rst_pop", 32'(o_FIFO_Rd), 32'd0);
        fifo_q.delete();
        exp_q.delete();
        exp_addr = 0;
        repeat (2) cyc();
        i_Rst_n = 1'b1;
        push(2 * BL);
        run_burst(0, 3, -1, 0, -1);
        run_burst(0, 3, -1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
- Producer-side counterpart to the SDRAM frame read path.
- Drains 32-bit words (four 8-bit pixels) from the render output FIFO and writes them to SDRAM in fixed-length bursts over the shared SDRAM command interface (o_Command / o_Data_Address / o_Data_Write / i_Data_Write_Done).
- Sits between the Julia render pipeline's output FIFO and the SDRAM arbiter; the address wraps at the frame size so it fills a single frame buffer continuously.

Parameters:
- WRITE_BURST_LENGTH, 8: words per write burst; range 1..255.
- FRAME_WORDS, 96000 (480*200): frame size in words; must be a multiple of WRITE_BURST_LENGTH.
- FIFO_USED_WIDTH, 10: width of the FIFO fill-level input (1024-deep FIFO).

Ports:
- i_Clk  in  1  system clock; all logic on the rising edge.
- i_Rst_n  in  1  reset; asynchronous assert, active-low.
- i_Bus_Grant  in  1  arbiter grant; a burst may start only while high.
- i_Frame_Start  in  1  one-cycle pulse: restart writing at address 0.
- i_Pixel_Out_Used  in  FIFO_USED_WIDTH  render FIFO fill level.
- i_Pixel_Out_Data  in  32  render FIFO head word (show-ahead FIFO).
- o_FIFO_Rd  out  1  pop strobe for the render FIFO (combinational).
- i_Data_Write_Done  in  1  controller accepted the current o_Data_Write word.
- o_Command  out  2  CMD_IDLE or CMD_WRITE only; this block never issues CMD_READ.
- o_Data_Address  out  22  word address of the current write.
- o_Data_Write  out  32  data for the current write.
- o_Busy  out  1  high from LOAD through the last accepted word of a burst.
- o_Frame_Done  out  1  one-cycle pulse when word FRAME_WORDS-1 is accepted.

Behaviour:
- Reset values (i_Rst_n low, asynchronous):
  - Registers: state=IDLE, o_Command=CMD_IDLE, o_Data_Address=0, o_Data_Write=0, countdown=0, o_Frame_Done=0, restart_pending=0.
  - Derived outputs: o_Busy=0, o_FIFO_Rd=0.
- Reset mid-burst: the burst is dropped immediately; the controller sees CMD_IDLE asynchronously.
- State IDLE:
  - If i_Bus_Grant && i_Pixel_Out_Used >= WRITE_BURST_LENGTH: go to LOAD.
  - Otherwise remain in IDLE, o_Command=CMD_IDLE.
- State LOAD (exactly 1 cycle):
  - o_FIFO_Rd=1.
  - o_Data_Write <= i_Pixel_Out_Data.
  - countdown <= WRITE_BURST_LENGTH-1.
  - o_Command <= CMD_WRITE; go to WRITE.
- State WRITE:
  - o_Command, o_Data_Address and o_Data_Write are held stable until i_Data_Write_Done.
  - On done: o_Data_Address <= (addr == FRAME_WORDS-1) ? 0 : addr+1.
  - On done with countdown != 0: countdown--, o_FIFO_Rd=1 in the same cycle, o_Data_Write <= i_Pixel_Out_Data.
  - On done with countdown == 0: o_Command <= CMD_IDLE, state <= IDLE, no pop.
- Pop rule: o_FIFO_Rd = (state==LOAD) | (state==WRITE & i_Data_Write_Done & countdown!=0).
  - Pops per burst = WRITE_BURST_LENGTH exactly.
  - Never pops when done is low.
- Latency: burst eligibility to first CMD_WRITE = 2 cycles (IDLE→LOAD→WRITE). Back-to-back bursts have a minimum of 2 idle cycles between the last done and the next CMD_WRITE.
- o_Frame_Done is registered, asserted the cycle after the done for address FRAME_WORDS-1.
- i_Frame_Start:
  - In IDLE: o_Data_Address <= 0 next cycle.
  - Outside IDLE: set restart_pending; the burst is never aborted. On return to IDLE, address <= 0 and restart_pending <= 0, overriding the normal increment.
  - In IDLE on the same cycle a burst becomes eligible: the restart takes priority and the burst is evaluated the next cycle.
- i_Bus_Grant is sampled only in IDLE; deassertion mid-burst has no effect (the arbiter must hold the grant per burst).
- FIFO underflow cannot occur: a burst starts only with >= WRITE_BURST_LENGTH words present.
- Width rules:
  - countdown is 8 bits.
  - Address compare is a full 22-bit compare against FRAME_WORDS-1.
  - Used compare is unsigned, FIFO_USED_WIDTH bits.

Decomposition:
- CMD_IDLE=2'd0, CMD_READ=2'd1 and CMD_WRITE=2'd2 live in the shared sdram.vh include alongside READ_BURST_LENGTH; add WRITE_BURST_LENGTH default there.
- State encoding is local.
- One natural sub-module: frame_addr_counter (22-bit wrap-at-FRAME_WORDS counter with sync clear and increment enable, plus the last-word flag). The same counter is reusable by the read path.

Test Plan:
1. Reset, then 8 words in the FIFO, grant high, done returned every 3rd cycle → CMD_WRITE on cycle 2; addresses 0..7; data matches FIFO order; 8 pops; CMD_IDLE after the 8th done.
2. Used=7 with grant high → no CMD_WRITE and no pop; raise Used to 8 → burst starts 2 cycles later.
3. Preload address 95992, write one burst → last addresses 95998, 95999, 0; o_Frame_Done pulses once, the cycle after the done for 95999.
4. i_Frame_Start pulsed at the 3rd word of a burst at address 40 → burst completes at address 47; next burst starts at 0.
5. Done held low for 20 cycles mid-burst → outputs stable, o_FIFO_Rd=0 throughout; resumes correctly when done rises.
6. i_Rst_n dropped mid-burst → o_Command=CMD_IDLE and o_Data_Address=0 without a clock edge; normal bursts after release.
